// File: rtl/uart_pkg.sv
// Shared UART types: data width, rx FIFO entry layout, parity modes.
// Imported by the rx/tx blocks and the receive FIFO.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_ENTRY_W = UART_DATA_W + 1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } uart_parity_e;

  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_edge_det.sv
// Rising-edge detector: one flop plus AND, async active-low reset.
// Ports: clk, rst_n, d_i (level in), rise_o (high on the 0->1 cycle).
module uart_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART: buffers {perr, byte} per rx_done edge,
// host pops via rd_en (1-cycle latency to rd_valid), sticky overflow.
// Ports: clk, rst_n, rx_done/rx_byte/rx_perr in; rd_en, ovf_clr in;
// rd_data/rd_perr/rd_valid, empty, full, count, overflow out.
// Option UART_RX_FIFO_ALMOST_FULL_EN adds AF_LEVEL and almost_full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_done,
  input  logic [UART_DATA_W-1:0] rx_byte,
  input  logic                   rx_perr,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_perr,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,output logic                  almost_full
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  uart_rx_entry_t mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  uart_rx_entry_t    rd_ent_q, rd_ent_d;
  logic              rd_valid_q;
  logic              ovf_q, ovf_d;
  logic              wr_req, wr_go, rd_go;

  uart_edge_det u_done_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rx_done),
    .rise_o (wr_req)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign rd_go = rd_en & ~empty;
  assign wr_go = wr_req & (~full | rd_go);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_ent_d = rd_ent_q;
    if (wr_go) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_go) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      rd_ent_d = mem_q[rd_ptr_q];
    end
    unique case (1'b1)
      wr_go & ~rd_go: count_d = count_q + (ADDR_W+1)'(1);
      rd_go & ~wr_go: count_d = count_q - (ADDR_W+1)'(1);
      default:        count_d = count_q;
    endcase
    // Set wins over clear.
    ovf_d = (wr_req & full & ~rd_go) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= '{perr: rx_perr, data: rx_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_ent_q   <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_ent_q   <= rd_ent_d;
      rd_valid_q <= rd_go;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data  = rd_ent_q.data;
  assign rd_perr  = rd_ent_q.perr;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic af_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) af_q <= 1'b0;
    else        af_q <= (count_d >= (ADDR_W+1)'(AF_LEVEL));
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed writes push expected
// entries, a negedge monitor pops and compares on every rd_valid.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_perr = 1'b0;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_done  (rx_done),
    .rx_byte  (rx_byte),
    .rx_perr  (rx_perr),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,.almost_full (almost_full)
`endif
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected none",
                 {rd_perr, rd_data});
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("pop_data", 32'(rd_data), 32'(e[7:0]));
        check("pop_perr", 32'(rd_perr), 32'(e[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b, input logic p, input bit acc);
    @(negedge clk);
    rx_byte = b;
    rx_perr = p;
    rx_done = 1'b1;
    if (acc) sb.push_back({p, b});
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pop(input bit exp_v);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_valid_lat", 32'(rd_valid), 32'(exp_v));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    rst_n = 1'b1;

    send(8'hA5, 1'b0, 1'b1);
    send(8'h3C, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    check("t1_count3", 32'(count), 3);
    pop(1'b1);
    check("t1_count2", 32'(count), 2);
    pop(1'b1);
    check("t1_count1", 32'(count), 1);
    pop(1'b1);
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    pop(1'b0);
    check("t1_hold_data", 32'(rd_data), 32'h FF);

    @(negedge clk);
    rx_byte = 8'h55;
    rx_perr = 1'b0;
    rx_done = 1'b1;
    sb.push_back({1'b0, 8'h55});
    repeat (20) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    check("t2_count1", 32'(count), 1);
    pop(1'b1);

    for (int i = 0; i < 16; i++)
      send(8'(8'h10 + i), i[0], 1'b1);
    check("t3_full", 32'(full), 1);
    check("t3_count16", 32'(count), 16);
    check("t3_ovf0", 32'(overflow), 0);
    send(8'h77, 1'b0, 1'b0);
    check("t3_ovf1", 32'(overflow), 1);
    check("t3_count_hold", 32'(count), 16);
    @(negedge clk);
    rx_byte = 8'h88;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    check("t3_set_wins", 32'(overflow), 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 0);

    @(negedge clk);
    rx_byte = 8'h99;
    rx_perr = 1'b1;
    rx_done = 1'b1;
    rd_en = 1'b1;
    sb.push_back({1'b1, 8'h99});
    @(negedge clk);
    rx_done = 1'b0;
    rd_en = 1'b0;
    check("t4_valid", 32'(rd_valid), 1);
    check("t4_count16", 32'(count), 16);
    check("t4_ovf0", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) pop(1'b1);
    check("t4_empty", 32'(empty), 1);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx_byte = 8'(i * 7 + 3);
      rx_perr = (i % 3 == 0);
      rx_done = 1'b1;
      rd_en = 1'b1;
      sb.push_back({rx_perr, rx_byte});
      @(negedge clk);
      rx_done = 1'b0;
      rd_en = 1'b0;
      if (i == 0) check("t5_first_rd_ignored", 32'(count), 1);
    end
    check("t5_count1", 32'(count), 1);
    pop(1'b1);
    check("t5_ovf0", 32'(overflow), 0);
    check("t5_empty", 32'(empty), 1);

    for (int i = 0; i < 16; i++)
      send(8'(8'hC0 + i), 1'b0, 1'b1);
    send(8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) pop(1'b1);
    check("t6_count5", 32'(count), 5);
    check("t6_ovf1", 32'(overflow), 1);
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    sb.delete();
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_valid", 32'(rd_valid), 0);
    check("t6_rst_data", 32'(rd_data), 0);
    check("t6_rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h12, 1'b0, 1'b1);
    check("t6_count1", 32'(count), 1);
    pop(1'b1);
    check("t6_empty", 32'(empty), 1);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART top.
- Captures each byte the receiver completes (rx_data, int_rx_finish, pari_err) into a small FIFO, with a per-entry parity-error tag.
- The host side can drain bytes at its own pace instead of racing the next frame.
- Sticky overflow flag records bytes lost while the buffer was full.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- rx_done  input  1  UART int_rx_finish; level or pulse, edge-detected internally.
- rx_byte  input  8  UART rx_data; stable when rx_done rises.
- rx_perr  input  1  UART pari_err; sampled with rx_byte.
- rd_en  input  1  pop request, one entry per cycle high.
- ovf_clr  input  1  clears the overflow flag.
- rd_data  output  8  popped byte, registered.
- rd_perr  output  1  parity tag of the popped byte, registered.
- rd_valid  output  1  one-cycle strobe: rd_data/rd_perr updated this cycle.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a byte was dropped.

Behaviour:
- Reset, asynchronous, rst_n low:
  - wr_ptr, rd_ptr, count = 0; empty=1, full=0; overflow=0.
  - rd_data=8'h00, rd_perr=0, rd_valid=0.
  - Edge-detect register = 0.
  - Memory contents are not reset.
- Write detection:
  - done_d <= rx_done each cycle; wr_req = rx_done & ~done_d.
  - Exactly one write per rising edge, regardless of how long rx_done stays high.
  - Written entry = {rx_perr, rx_byte} sampled in the wr_req cycle.
- Write accept: wr_req & (~full | rd_go).
  - The entry is stored at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- Read accept: rd_go = rd_en & ~empty.
  - Next cycle: rd_data/rd_perr = entry at the old rd_ptr, rd_valid=1.
  - rd_ptr increments with wrap.
  - Latency: one clock from rd_en to rd_valid.
- rd_en while empty:
  - Ignored; rd_valid=0 and rd_data holds its previous value.
- Count update:
  - +1 on write-only; -1 on read-only.
  - Unchanged when both are accepted or neither is.
  - empty and full are decoded from the registered count (no combinational input path).
- Simultaneous read and write when full: both accepted, count stays DEPTH, no overflow.
- Simultaneous read and write when empty: the write is accepted; the read is not (empty was high). Count becomes 1.
- Overflow:
  - wr_req while full and no rd_go → byte dropped, overflow <= 1.
  - ovf_clr clears overflow.
  - Set wins over clear when both occur in the same cycle.
- Pointers carry no extra wrap bit; full/empty come from count only.
- Reset asserted mid-operation: all pending data is discarded; the first rx_done edge after release is accepted normally.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2).
  - Adds output port almost_full (1 bit, reset 0), registered, high when count >= AF_LEVEL.
  - Used for host flow-control/interrupt.
- When undefined:
  - Neither the port nor the parameter exists.
  - Logic is otherwise identical.

Decomposition:
- Package uart_pkg:
  - UART_DATA_W=8.
  - Entry width UART_DATA_W+1.
  - Parity-mode encodings: NONE=2'b00, ODD=2'b01, EVEN=2'b10, shared with the rx/tx blocks.
- One sub-module: uart_edge_det.
  - Single flop plus AND, async active-low reset.
  - Reused later for the tx_start path.
- Memory inferred as a register array inside uart_rx_fifo; no separate RAM wrapper.

Test Plan:
- Write 3 bytes (0xA5 perr=0, 0x3C perr=1, 0xFF perr=0) via rx_done pulses, then 3 rd_en cycles:
  - rd_valid strobes one cycle after each rd_en.
  - Data/tag come out in order.
  - count steps 3→0; empty=1 at the end.
- Hold rx_done high for 20 cycles with rx_byte=0x55 → exactly one entry written; count=1.
- Fill to 16, then one more edge with 0x77 and no rd_en:
  - full=1, overflow=1, count=16, 0x77 dropped.
  - Assert ovf_clr together with a 17th edge → overflow stays 1.
  - ovf_clr alone → overflow=0.
- Full FIFO, rx_done edge and rd_en in the same cycle:
  - Both accepted, count=16, overflow=0.
  - Oldest byte popped; the new byte is the last one out after 16 reads.
- Write/read 40 bytes in a streaming pattern (pointer wrap 2.5×) → output sequence matches input sequence exactly; no overflow.
- Assert rst_n low with count=5, mid-read:
  - Immediately count=0, empty=1, rd_valid=0, rd_data=0x00, overflow=0.
  - After release, one write of 0x12 then a read returns 0x12.
